// File: rtl/debug_access_controller.sv
// debug_access_controller: halts and drains the pipeline for host register-file access, then resumes
// Ports: clock/reset (sync, active-low); host_halt_request/host_halted handshake;
//   host_cmd_* command channel, host_rsp_* one-cycle response; write_conflict sticky flag;
//   pipeline_stall to the core; pipeline_* register-file-facing inputs muxed onto register_file_*.
module debug_access_controller #(
  parameter int ADDRESS_WIDTH  = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int PIPELINE_DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     host_halt_request,
  output logic                     host_halted,
  input  logic                     host_cmd_valid,
  output logic                     host_cmd_ready,
  input  logic                     host_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] host_cmd_address,
  input  logic [DATA_WIDTH-1:0]    host_cmd_data,
  output logic                     host_rsp_valid,
  output logic [DATA_WIDTH-1:0]    host_rsp_data,
  output logic                     write_conflict,
  output logic                     pipeline_stall,
  input  logic                     pipeline_write_enable,
  input  logic [ADDRESS_WIDTH-1:0] pipeline_write_address,
  input  logic [DATA_WIDTH-1:0]    pipeline_write_value,
  input  logic [ADDRESS_WIDTH-1:0] pipeline_read_address_1,
  output logic                     register_file_write_enable,
  output logic [ADDRESS_WIDTH-1:0] register_file_write_address,
  output logic [DATA_WIDTH-1:0]    register_file_write_value,
  output logic [ADDRESS_WIDTH-1:0] register_file_read_address_1,
  input  logic [DATA_WIDTH-1:0]    register_file_read_value_1
);
  localparam int CW = $clog2(PIPELINE_DEPTH + 1);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED, ACCESS} state_t;
  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     wr_q, wr_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic                     conflict_q, conflict_d;
  logic                     own, acc, accept;
  always_comb begin
    own    = state_q == HALTED || state_q == ACCESS;
    acc    = state_q == ACCESS;
    accept = state_q == HALTED && host_cmd_valid;
    // an accepted command wins over a simultaneous request drop
    state_d = state_q == RUN    ? (host_halt_request ? DRAIN : RUN) :
              state_q == DRAIN  ? (cnt_q == '0 ? HALTED : DRAIN) :
              state_q == HALTED ? (host_cmd_valid ? ACCESS : host_halt_request ? HALTED : RUN) :
                                  HALTED;
    cnt_d = state_q == RUN && host_halt_request ? CW'(PIPELINE_DEPTH - 1) :
            state_q == DRAIN && cnt_q != '0     ? cnt_q - CW'(1) : cnt_q;
    wr_d        = accept ? host_cmd_write : wr_q;
    addr_d      = accept ? host_cmd_address : addr_q;
    data_d      = accept ? host_cmd_data : data_q;
    rsp_valid_d = acc;
    rsp_data_d  = acc ? (wr_q ? data_q : register_file_read_value_1) : rsp_data_q;
    conflict_d  = conflict_q | (own & pipeline_write_enable);
    pipeline_stall = state_q != RUN;
    host_halted    = own;
    host_cmd_ready = state_q == HALTED;
    host_rsp_valid = rsp_valid_q;
    host_rsp_data  = rsp_data_q;
    write_conflict = conflict_q;
    // reset gates the write port so an aborted access never commits
    register_file_write_enable   = reset & (acc ? wr_q : ~own & pipeline_write_enable);
    register_file_write_address  = acc ? addr_q : pipeline_write_address;
    register_file_write_value    = acc ? data_q : pipeline_write_value;
    register_file_read_address_1 = acc ? addr_q : pipeline_read_address_1;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      conflict_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      conflict_q  <= conflict_d;
    end
  end
endmodule
